// File: rtl/mips_mem_pkg.sv
// Shared constants and payload types for the sequential instruction memory.
package mips_mem_pkg;

    // Fetch sequencer state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Word returned on any fetch error
    localparam logic [31:0] NOP = 32'h0000_0000;

    // Wait-state down-counter width (covers 0..15)
    localparam int unsigned CNT_W = 4;

    // One fetch response: instruction word plus its error flags
    typedef struct packed {
        logic [31:0] instr;
        logic        err_misalign;
        logic        err_range;
    } resp_t;

endpackage

// File: rtl/imem_array.sv
// DEPTH x 32 instruction storage: one synchronous write port, one asynchronous read port.
module imem_array #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata_c
);

    // Power-up contents are zero; reset never touches the array.
    logic [31:0] mem [DEPTH] = '{default: 32'h0};

    // Program-load write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read: a same-edge write is not yet visible, giving read-before-write
    assign rdata_c = mem[raddr];

endmodule

// File: rtl/instruction_mem_seq.sv
// Instruction memory with a request/response fetch port and configurable wait states.
module instruction_mem_seq
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned IDX_W       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [31:0]      addr,
    output logic             ready,
    output logic             rvalid,
    output logic [31:0]      instr,
    output logic             err_misalign,
    output logic             err_range,
    input  logic             prog_we,
    input  logic [IDX_W-1:0] prog_addr,
    input  logic [31:0]      prog_data
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             accept_c;
    logic             load_out_c;
    logic [IDX_W-1:0] rd_idx_c;
    logic [31:0]      rdata_c;
    resp_t            fetch_c;
    resp_t            resp_src_c;
    resp_t            hold;
    resp_t            out_q;

    assign accept_c = req && ready;
    assign rd_idx_c = addr[IDX_W+1:2];

    imem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .we      (prog_we),
        .waddr   (prog_addr),
        .wdata   (prog_data),
        .raddr   (rd_idx_c),
        .rdata_c (rdata_c)
    );

    // Decode the incoming address into a response; errors force a NOP word
    always_comb begin
        fetch_c              = '0;
        fetch_c.err_misalign = (addr[1:0] != 2'b00);
        fetch_c.err_range    = ((addr >> (IDX_W + 2)) != 32'h0);
        fetch_c.instr        = (fetch_c.err_misalign || fetch_c.err_range) ? NOP : rdata_c;
    end

    // With no wait states the response bypasses the holding register
    assign resp_src_c = (WAIT_STATES == 0) ? fetch_c : hold;

    // Next-state, counter and output-load decisions
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        load_out_c = 1'b0;
        case (state)
            IDLE, RESP: begin
                if (accept_c) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt  = RESP;
                        load_out_c = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_W'(WAIT_STATES);
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt  = RESP;
                    load_out_c = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and handshake registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            ready  <= 1'b1;
            rvalid <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            ready  <= (state_nxt != WAIT);
            rvalid <= (state_nxt == RESP);
        end
    end

    // Capture the fetched word and flags at accept so later array writes cannot disturb it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold <= '0;
        end else if (accept_c) begin
            hold <= fetch_c;
        end
    end

    // Response registers: updated only when a response is presented, held otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= '0;
        end else if (load_out_c) begin
            out_q <= resp_src_c;
        end
    end

    assign instr        = out_q.instr;
    assign err_misalign = out_q.err_misalign;
    assign err_range    = out_q.err_range;

endmodule

// File: doc/instruction_mem_seq.md
INSTRUCTION_MEM_SEQ -- requirements
Module: instruction_mem_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit words; power of two, >= 4.
REQ-002 SHALL have parameter WAIT_STATES, default 1, extra cycles between accept and response; range 0..15.
REQ-003 SHALL have parameter IDX_W, default $clog2(DEPTH), word-index width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req  input  1  fetch request, accepted when req && ready.
REQ-007 SHALL have port addr  input  32  byte address of fetch.
REQ-008 SHALL have port ready  output  1  block can accept a request this cycle.
REQ-009 SHALL have port rvalid  output  1  instr and error flags valid, one-cycle pulse.
REQ-010 SHALL have port instr  output  32  fetched instruction word.
REQ-011 SHALL have port err_misalign  output  1  addr[1:0] != 0 at accept; qualified by rvalid.
REQ-012 SHALL have port err_range  output  1  word index >= DEPTH at accept; qualified by rvalid.
REQ-013 SHALL have port prog_we  input  1  program-load write enable.
REQ-014 SHALL have port prog_addr  input  IDX_W  word index for program load.
REQ-015 SHALL have port prog_data  input  32  word written on prog_we.

Function
REQ-016 SHALL form the word index from addr[IDX_W+1:2]; out of range when any of addr[31:IDX_W+2] is non-zero.
REQ-017 SHALL implement states IDLE, WAIT, RESP; ready = 1 in IDLE and RESP, 0 in WAIT.
REQ-018 SHALL, on accept, capture the array word (or 32'h0 on misalign/range error) and both error flags into holding registers.
REQ-019 SHALL transition IDLE/RESP -> WAIT on accept when WAIT_STATES > 0, loading a down-counter with WAIT_STATES; IDLE/RESP -> RESP on accept when WAIT_STATES = 0.
REQ-020 SHALL decrement the counter in WAIT and go to RESP when it reaches 0 (WAIT lasts exactly WAIT_STATES cycles).
REQ-021 SHALL assert rvalid for exactly one cycle, in RESP, WAIT_STATES+1 cycles after the accept edge.
REQ-022 SHALL, in RESP without accept, return to IDLE; with accept, proceed per REQ-019 (back-to-back: with WAIT_STATES=0 one response per cycle).
REQ-023 SHALL hold instr and error flags stable from RESP until the next response; instr is 32'h0 (NOP) on any error.
REQ-024 SHALL write prog_data to array[prog_addr] on rising edge when prog_we = 1, in any state.
REQ-025 SHALL, for prog write and accept to the same index in one cycle, return the old word (read-before-write).
REQ-026 SHALL NOT alter a pending response when the array is written after accept.
REQ-027 SHALL report both flags when an address is both misaligned and out of range.

Reset
REQ-028 SHALL on reset force state IDLE, counter 0, rvalid 0, instr 32'h0, err_misalign 0, err_range 0, ready 1.
REQ-029 SHALL abort any in-flight fetch on reset with no rvalid pulse generated for it.
REQ-030 SHALL NOT clear array contents on reset; array is zero-initialised at time 0 only.

Structure
REQ-031 SHALL place state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2) and NOP constant 32'h0 in shared package mips_mem_pkg.
REQ-032 SHALL instantiate one sub-module, imem_array (DEPTH x 32, one sync write port, one async read port).

Verification
REQ-033 SHALL: WAIT_STATES=1, program [0]=32'h8C100000, req addr=0 at cycle t -> ready=0 at t+1, rvalid=1 at t+2 with instr=32'h8C100000, flags 0.
REQ-034 SHALL: WAIT_STATES=0, req held 4 cycles on addr 0,4,8,12 -> four consecutive rvalid pulses with words [0]..[3] in order.
REQ-035 SHALL: req addr=32'h6 -> rvalid with err_misalign=1, instr=32'h0; req addr=32'h100 (DEPTH=64) -> err_range=1, instr=32'h0.
REQ-036 SHALL: prog_we to index 5 with 32'hDEADBEEF in same cycle as accept of addr=20 -> response returns old word; next fetch of 20 returns 32'hDEADBEEF.
REQ-037 SHALL: WAIT_STATES=3, reset asserted during WAIT -> no rvalid ever for that fetch, outputs per REQ-028, array contents unchanged.
